// File: rtl/fas_chk_pkg.sv
// Shared definitions for the FAS result checker.
//   state_t       : run-control states of the checker
//   ERR_* indices : bit positions of the sticky cause flags in err_flags
package fas_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int ERR_LIMIT    = 0;
  localparam int ERR_UNDERRUN = 1;
  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_W        = 3;

endpackage

// File: rtl/fas_chk_fifo.sv
// Golden-beat buffer for the FAS result checker (first-word fall-through).
//   clk, rst (async, active-low)  : clock / reset of the pointers
//   flush                         : empties the buffer, wins over push/pop
//   push, wdata                   : write one beat (ignored when full)
//   pop                           : drop the head beat (ignored when empty)
//   rdata                         : current head beat
//   full, empty                   : occupancy status
// DEPTH must be a power of two and at least 2.
module fas_chk_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fas_result_checker.sv
// FAS result checker: compares a DUT result stream against a buffered golden
// stream lane by lane with a per-field tolerance, and reports pass/fail.
//   clk, rst (async, active-low), start (one-cycle re-arm pulse)
//   gold_valid/gold_data/gold_ready : golden beats, valid/ready handshake
//   dut_valid/dut_data              : DUT beats, no backpressure
//   busy, pass, fail, done          : run status (done = pass | fail)
//   fail_cnt                        : saturating count of failed lane words
//   lane_fail                       : failure mask of the last compared beat
//   first_err_idx                   : index of the first failing lane word
//   err_limit/err_underrun/err_timeout : sticky cause flags
module fas_result_checker
  import fas_chk_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int FW         = 16,
  parameter int FIELDS     = 2,
  parameter int TOL        = 3,
  parameter int TOTAL      = 1024,
  parameter int FAIL_LIMIT = 48,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          gold_valid,
  input  logic [LANES*FIELDS*FW-1:0]    gold_data,
  output logic                          gold_ready,
  input  logic                          dut_valid,
  input  logic [LANES*FIELDS*FW-1:0]    dut_data,
  output logic                          busy,
  output logic                          pass,
  output logic                          fail,
  output logic                          done,
  output logic [$clog2(TOTAL+1)-1:0]    fail_cnt,
  output logic [LANES-1:0]              lane_fail,
  output logic [$clog2(TOTAL)-1:0]      first_err_idx,
  output logic                          err_limit,
  output logic                          err_underrun,
  output logic                          err_timeout
);

  localparam int BW = LANES * FIELDS * FW;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int IW = $clog2(TOTAL);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(LANES + 1);
  localparam logic signed [FW-1:0] TOL_S = FW'(TOL);

  // A field passes when the wrapped difference lies within +/-TOL.
  function automatic logic field_ok(input logic [FW-1:0] g, input logic [FW-1:0] d);
    logic signed [FW-1:0] diff;
    diff = g - d;
    return (diff >= -TOL_S) && (diff <= TOL_S);
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + {{(CW + 1 - PW){1'b0}}, b};
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  state_t          state;
  state_t          state_nxt;
  logic            set_limit;
  logic            set_timeout;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [BW-1:0]   gold_head;

  logic            vld_p0;
  logic [LANES-1:0] lane_fail_p0;
  logic [IW-1:0]   first_idx_p0;
  logic [CW-1:0]   fail_cnt_nxt;
  logic [CW-1:0]   sample_cnt_nxt;

  logic [LANES-1:0] lane_fail_p1;
  logic [CW-1:0]   fail_cnt_p1;
  logic [CW-1:0]   sample_cnt_p1;
  logic [IW-1:0]   first_err_p1;
  logic [ERR_W-1:0] err_flags;
  logic [TW-1:0]   idle_cnt;

  assign vld_p0    = (state == ST_RUN) && dut_valid;
  assign fifo_push = gold_valid && gold_ready && !start;
  assign fifo_pop  = vld_p0 && !fifo_empty && !start;

  fas_chk_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_gold_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (fifo_push),
    .wdata (gold_data),
    .pop   (fifo_pop),
    .rdata (gold_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- stage p0: lane compare against the FIFO head ----
  always_comb begin
    lane_fail_p0 = '0;
    for (int l = 0; l < LANES; l++) begin
      if (fifo_empty) begin
        lane_fail_p0[l] = 1'b1;
      end else begin
        for (int f = 0; f < FIELDS; f++) begin
          if (!field_ok(gold_head[(l*FIELDS+f)*FW +: FW], dut_data[(l*FIELDS+f)*FW +: FW]))
            lane_fail_p0[l] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    first_idx_p0 = sample_cnt_p1[IW-1:0];
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_fail_p0[l]) first_idx_p0 = sample_cnt_p1[IW-1:0] + IW'(l);
    end
  end

  assign fail_cnt_nxt   = vld_p0 ? sat_add(fail_cnt_p1, PW'($countones(lane_fail_p0))) : fail_cnt_p1;
  assign sample_cnt_nxt = vld_p0 ? sample_cnt_p1 + CW'(LANES) : sample_cnt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    set_limit   = 1'b0;
    set_timeout = 1'b0;
    if (start) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (vld_p0) begin
        if (fail_cnt_nxt >= CW'(FAIL_LIMIT)) begin
          state_nxt = ST_FAIL;
          set_limit = 1'b1;
        end else if (sample_cnt_nxt >= CW'(TOTAL)) begin
          state_nxt = (fail_cnt_nxt == '0) ? ST_PASS : ST_FAIL;
        end
      end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
        state_nxt   = ST_FAIL;
        set_timeout = 1'b1;
      end
    end
  end

  always_comb begin
    busy       = (state == ST_RUN);
    pass       = (state == ST_PASS);
    fail       = (state == ST_FAIL);
    done       = pass || fail;
    gold_ready = (state == ST_RUN) && !fifo_full;
  end

  // ---- stage p1: registered compare results and run counters ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_fail_p1  <= '0;
      fail_cnt_p1   <= '0;
      sample_cnt_p1 <= '0;
      first_err_p1  <= '0;
      err_flags     <= '0;
      idle_cnt      <= '0;
    end else if (start) begin
      lane_fail_p1  <= '0;
      fail_cnt_p1   <= '0;
      sample_cnt_p1 <= '0;
      first_err_p1  <= '0;
      err_flags     <= '0;
      idle_cnt      <= '0;
    end else if (state == ST_RUN) begin
      idle_cnt <= dut_valid ? '0 : idle_cnt + TW'(1);
      if (vld_p0) begin
        lane_fail_p1  <= lane_fail_p0;
        fail_cnt_p1   <= fail_cnt_nxt;
        sample_cnt_p1 <= sample_cnt_nxt;
        if ((fail_cnt_p1 == '0) && (|lane_fail_p0)) first_err_p1 <= first_idx_p0;
        if (fifo_empty) err_flags[ERR_UNDERRUN] <= 1'b1;
      end
      if (set_limit)   err_flags[ERR_LIMIT]   <= 1'b1;
      if (set_timeout) err_flags[ERR_TIMEOUT] <= 1'b1;
    end
  end

  assign lane_fail     = lane_fail_p1;
  assign fail_cnt      = fail_cnt_p1;
  assign first_err_idx = first_err_p1;
  assign err_limit     = err_flags[ERR_LIMIT];
  assign err_underrun  = err_flags[ERR_UNDERRUN];
  assign err_timeout   = err_flags[ERR_TIMEOUT];

endmodule

// File: tb/tb_fas_result_checker.sv
module tb_fas_result_checker;

  localparam int LANES      = 16;
  localparam int FW         = 16;
  localparam int FIELDS     = 2;
  localparam int TOL        = 3;
  localparam int TOTAL      = 1024;
  localparam int FAIL_LIMIT = 48;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 20;
  localparam int BW         = LANES * FIELDS * FW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             gold_valid;
  logic [BW-1:0]    gold_data;
  logic             gold_ready;
  logic             dut_valid;
  logic [BW-1:0]    dut_data;
  logic             busy, pass, fail, done;
  logic [10:0]      fail_cnt;
  logic [LANES-1:0] lane_fail;
  logic [9:0]       first_err_idx;
  logic             err_limit, err_underrun, err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0]    gq[$];
  logic [LANES-1:0] exp_q[$];
  logic [BW-1:0]    gbeat [0:63];

  fas_result_checker #(
    .LANES(LANES), .FW(FW), .FIELDS(FIELDS), .TOL(TOL), .TOTAL(TOTAL),
    .FAIL_LIMIT(FAIL_LIMIT), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .gold_valid(gold_valid), .gold_data(gold_data), .gold_ready(gold_ready),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(busy), .pass(pass), .fail(fail), .done(done),
    .fail_cnt(fail_cnt), .lane_fail(lane_fail), .first_err_idx(first_err_idx),
    .err_limit(err_limit), .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: field passes if (g-d) mod 2^FW is in [0,TOL] or [2^FW-TOL, 2^FW-1].
  function automatic logic [LANES-1:0] model_mask(input logic [BW-1:0] g, input logic [BW-1:0] d);
    logic [LANES-1:0] m;
    int unsigned gv, dv, diff, modv;
    m = '0;
    modv = 32'd1 << FW;
    for (int l = 0; l < LANES; l++) begin
      for (int f = 0; f < FIELDS; f++) begin
        gv = 32'(g[(l*FIELDS+f)*FW +: FW]);
        dv = 32'(d[(l*FIELDS+f)*FW +: FW]);
        diff = (gv + modv - dv) % modv;
        if (!(diff <= TOL || diff >= modv - TOL)) m[l] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [LANES-1:0] pop_exp();
    if (exp_q.size() == 0) return {LANES{1'bx}};
    return exp_q.pop_front();
  endfunction

  task automatic gen_gold(input int n);
    for (int k = 0; k < n; k++)
      for (int w = 0; w < BW / 32; w++)
        gbeat[k][w*32 +: 32] = $urandom();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gq.delete();
    exp_q.delete();
  endtask

  // One clock of stimulus; the scoreboard records the expected mask for any DUT beat.
  task automatic send_beat(input logic gv, input logic [BW-1:0] gd,
                           input logic dv, input logic [BW-1:0] dd);
    gold_valid = gv;
    gold_data  = gd;
    dut_valid  = dv;
    dut_data   = dd;
    if (dv && busy) begin
      if (gq.size() == 0) exp_q.push_back('1);
      else                exp_q.push_back(model_mask(gq.pop_front(), dd));
    end
    if (gv && gold_ready) gq.push_back(gd);
    @(posedge clk); #1;
    gold_valid = 1'b0;
    dut_valid  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_status got busy=%b pass=%b fail=%b done=%b want 0000", busy, pass, fail, done); end
    checks++; if (fail_cnt !== '0 || lane_fail !== '0 || first_err_idx !== '0) begin
      failures++; $display("FAIL reset_counts got fail_cnt=%0d lane_fail=%h idx=%0d want 0", fail_cnt, lane_fail, first_err_idx); end
    checks++; if ({err_limit, err_underrun, err_timeout} !== 3'b000 || gold_ready !== 1'b0) begin
      failures++; $display("FAIL reset_flags got err=%b%b%b gold_ready=%b want 0", err_limit, err_underrun, err_timeout, gold_ready); end
  endtask

  task automatic test_match();
    logic [LANES-1:0] e;
    do_start();
    gen_gold(64);
    send_beat(1'b1, gbeat[0], 1'b0, '0);
    for (int k = 0; k < 64; k++) begin
      send_beat(k < 63, gbeat[(k < 63) ? k + 1 : k], 1'b1, gbeat[k]);
      e = pop_exp();
      checks++; if (lane_fail !== e || fail_cnt !== '0) begin
        failures++; $display("FAIL match_beat k=%0d got lane_fail=%h fail_cnt=%0d want %h 0", k, lane_fail, fail_cnt, e); end
      if (k == 62) begin
        checks++; if (pass !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL match_early_pass got pass=%b busy=%b want 0 1", pass, busy); end
      end
    end
    checks++; if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL match_pass got pass=%b fail=%b done=%b busy=%b want 1 0 1 0", pass, fail, done, busy); end
    checks++; if (gold_ready !== 1'b0) begin
      failures++; $display("FAIL match_ready_idle got gold_ready=%b want 0", gold_ready); end
    send_beat(1'b0, '0, 1'b1, '1);
    checks++; if (pass !== 1'b1 || fail_cnt !== '0 || lane_fail !== '0) begin
      failures++; $display("FAIL match_hold got pass=%b fail_cnt=%0d lane_fail=%h want 1 0 0", pass, fail_cnt, lane_fail); end
  endtask

  task automatic test_tolerance();
    logic [BW-1:0]    d [0:3];
    logic [LANES-1:0] e;
    logic [FW-1:0]    v;
    do_start();
    gen_gold(4);
    for (int k = 0; k < 3; k++) gbeat[k][(5*2+0)*FW +: FW] = 16'h0000;
    gbeat[0][(6*2+1)*FW +: FW] = 16'hFFFD;
    gbeat[0][(7*2+0)*FW +: FW] = 16'h7FFF;
    for (int k = 0; k < 4; k++) d[k] = gbeat[k];
    d[0][(5*2+0)*FW +: FW] = 16'hFFFD;
    d[1][(5*2+0)*FW +: FW] = 16'hFFFD;
    d[0][(6*2+1)*FW +: FW] = 16'h0000;
    d[0][(7*2+0)*FW +: FW] = 16'h8000;
    d[2][(5*2+0)*FW +: FW] = 16'hFFFC;
    v = gbeat[3][(0*2+1)*FW +: FW] + 16'd4;
    d[3][(0*2+1)*FW +: FW] = v;
    send_beat(1'b1, gbeat[0], 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      send_beat(k < 3, gbeat[(k < 3) ? k + 1 : k], 1'b1, d[k]);
      e = pop_exp();
      checks++; if (lane_fail !== e) begin
        failures++; $display("FAIL tol_model k=%0d got lane_fail=%h want %h", k, lane_fail, e); end
      if (k < 2) begin
        checks++; if (lane_fail !== '0 || fail_cnt !== '0) begin
          failures++; $display("FAIL tol_within k=%0d got lane_fail=%h fail_cnt=%0d want 0 0", k, lane_fail, fail_cnt); end
      end else if (k == 2) begin
        checks++; if (lane_fail !== 16'h0020 || fail_cnt !== 11'd1 || first_err_idx !== 10'd37) begin
          failures++; $display("FAIL tol_outside got lane_fail=%h fail_cnt=%0d idx=%0d want 0020 1 37", lane_fail, fail_cnt, first_err_idx); end
      end else begin
        checks++; if (lane_fail !== 16'h0001 || fail_cnt !== 11'd2 || first_err_idx !== 10'd37 || err_underrun !== 1'b0) begin
          failures++; $display("FAIL tol_first_kept got lane_fail=%h fail_cnt=%0d idx=%0d undr=%b want 0001 2 37 0", lane_fail, fail_cnt, first_err_idx, err_underrun); end
      end
    end
  endtask

  task automatic test_limit();
    logic [BW-1:0]    d [0:2];
    logic [LANES-1:0] e;
    do_start();
    gen_gold(3);
    for (int k = 0; k < 3; k++) begin
      d[k] = gbeat[k];
      for (int l = 0; l < LANES; l++)
        d[k][(l*2+0)*FW +: FW] = gbeat[k][(l*2+0)*FW +: FW] + 16'd4;
    end
    send_beat(1'b1, gbeat[0], 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      send_beat(k < 2, gbeat[(k < 2) ? k + 1 : k], 1'b1, d[k]);
      e = pop_exp();
      checks++; if (lane_fail !== e || lane_fail !== 16'hFFFF || fail_cnt !== 11'(16 * (k + 1))) begin
        failures++; $display("FAIL limit_beat k=%0d got lane_fail=%h fail_cnt=%0d want %h %0d", k, lane_fail, fail_cnt, e, 16 * (k + 1)); end
      checks++; if (fail !== (k == 2)) begin
        failures++; $display("FAIL limit_fail_timing k=%0d got fail=%b want %b", k, fail, (k == 2)); end
    end
    checks++; if (err_limit !== 1'b1 || pass !== 1'b0 || busy !== 1'b0 || first_err_idx !== '0) begin
      failures++; $display("FAIL limit_flags got err_limit=%b pass=%b busy=%b idx=%0d want 1 0 0 0", err_limit, pass, busy, first_err_idx); end
  endtask

  task automatic test_underrun();
    logic [BW-1:0]    g;
    logic [LANES-1:0] e;
    do_start();
    gen_gold(1);
    g = gbeat[0];
    send_beat(1'b0, '0, 1'b1, g);
    e = pop_exp();
    checks++; if (err_underrun !== 1'b1 || fail_cnt !== 11'd16 || lane_fail !== e || busy !== 1'b1) begin
      failures++; $display("FAIL underrun_empty got undr=%b fail_cnt=%0d lane_fail=%h busy=%b want 1 16 %h 1", err_underrun, fail_cnt, lane_fail, busy, e); end
    send_beat(1'b1, g, 1'b1, g);
    e = pop_exp();
    checks++; if (fail_cnt !== 11'd32 || lane_fail !== e) begin
      failures++; $display("FAIL underrun_no_bypass got fail_cnt=%0d lane_fail=%h want 32 %h", fail_cnt, lane_fail, e); end
    send_beat(1'b0, '0, 1'b1, g);
    e = pop_exp();
    checks++; if (fail_cnt !== 11'd32 || lane_fail !== e || lane_fail !== '0 || first_err_idx !== '0) begin
      failures++; $display("FAIL underrun_recover got fail_cnt=%0d lane_fail=%h idx=%0d want 32 %h 0", fail_cnt, lane_fail, first_err_idx, e); end
  endtask

  task automatic test_timeout();
    do_start();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checks++; if (fail !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early got fail=%b busy=%b want 0 1", fail, busy); end
    @(posedge clk); #1;
    checks++; if (fail !== 1'b1 || err_timeout !== 1'b1 || err_limit !== 1'b0 || err_underrun !== 1'b0) begin
      failures++; $display("FAIL timeout_fire got fail=%b err_t=%b err_l=%b err_u=%b want 1 1 0 0", fail, err_timeout, err_limit, err_underrun); end
    send_beat(1'b0, '0, 1'b1, '1);
    checks++; if (fail !== 1'b1 || fail_cnt !== '0 || lane_fail !== '0) begin
      failures++; $display("FAIL timeout_hold got fail=%b fail_cnt=%0d lane_fail=%h want 1 0 0", fail, fail_cnt, lane_fail); end
  endtask

  task automatic test_restart();
    logic [BW-1:0]    g;
    logic [LANES-1:0] e;
    do_start();
    gen_gold(1);
    g = gbeat[0];
    send_beat(1'b0, '0, 1'b1, g);
    void'(pop_exp());
    send_beat(1'b1, g, 1'b0, '0);
    send_beat(1'b1, g, 1'b0, '0);
    checks++; if (fail_cnt !== 11'd16 || err_underrun !== 1'b1) begin
      failures++; $display("FAIL restart_pre got fail_cnt=%0d undr=%b want 16 1", fail_cnt, err_underrun); end
    do_start();
    checks++; if (fail_cnt !== '0 || {err_limit, err_underrun, err_timeout} !== 3'b000 || lane_fail !== '0 || first_err_idx !== '0) begin
      failures++; $display("FAIL restart_clear got fail_cnt=%0d err=%b%b%b lane_fail=%h idx=%0d want 0", fail_cnt, err_limit, err_underrun, err_timeout, lane_fail, first_err_idx); end
    checks++; if (busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0 || gold_ready !== 1'b1) begin
      failures++; $display("FAIL restart_state got busy=%b pass=%b fail=%b ready=%b want 1 0 0 1", busy, pass, fail, gold_ready); end
    send_beat(1'b0, '0, 1'b1, g);
    e = pop_exp();
    checks++; if (err_underrun !== 1'b1 || lane_fail !== e || lane_fail !== 16'hFFFF) begin
      failures++; $display("FAIL restart_flushed got undr=%b lane_fail=%h want 1 %h", err_underrun, lane_fail, e); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || fail_cnt !== '0 || err_underrun !== 1'b0 || lane_fail !== '0) begin
      failures++; $display("FAIL async_reset got busy=%b fail_cnt=%0d undr=%b lane_fail=%h want 0 0 0 0", busy, fail_cnt, err_underrun, lane_fail); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    gold_valid = 1'b0;
    gold_data  = '0;
    dut_valid  = 1'b0;
    dut_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_match();
    test_tolerance();
    test_limit();
    test_underrun();
    test_timeout();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
